// File: rtl/ram_ctrl_pkg.sv
// Shared state encoding, command-record width and default parameters for the
// RAM request controller and its command FIFO.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Command record is {write, address, data}
  localparam int unsigned CMD_WIDTH = 1 + DEF_ADDR_WIDTH + DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WRITE        = 2'd1,
    READ_ISSUE   = 2'd2,
    READ_CAPTURE = 2'd3
  } ram_state_e;

  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/ram_cmd_fifo.sv
// Show-ahead synchronous command FIFO; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy register.
module ram_cmd_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CMD_WIDTH,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty_c    = (r_wr_ptr == r_rd_ptr);
  assign o_full_c     = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                        (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign o_count_c    = r_wr_ptr - r_rd_ptr;
  assign o_pop_data_c = r_mem[r_rd_ptr[IDX_W-1:0]];
  assign w_do_push    = i_push && !o_full_c;
  assign w_do_pop     = i_pop && !o_empty_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/ram_request_controller.sv
// Buffers RAM read/write commands and sequences them onto one RAM port in order.
// Optional macro RAM_REQ_STATS_EN adds saturating write/read completion counters.
module ram_request_controller
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  write_enable,
  output logic                  output_enable,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic [15:0]           write_count,
  output logic [15:0]           read_count
);

  localparam int unsigned CMD_W = cmd_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;

  ram_state_e            r_state;
  ram_state_e            w_next_state;
  logic                  r_write_enable, r_output_enable, r_rsp_valid, r_busy;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_data_in, r_rsp_data;

  logic                  w_we_next, w_oe_next, w_rsp_valid_next, w_busy_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] w_din_next, w_rsp_data_next;

  logic                  w_push, w_pop, w_full, w_empty;
  logic [CMD_W-1:0]      w_head;
  logic [PTR_W-1:0]      w_count, w_count_next;
  logic                  w_head_write;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;

  assign cmd_ready    = !w_full;
  assign w_push       = cmd_valid && !w_full;
  assign w_head_write = w_head[CMD_W-1];
  assign w_head_addr  = w_head[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
  assign w_head_data  = w_head[DATA_WIDTH-1:0];

  ram_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_data  ({cmd_write, cmd_address, cmd_data}),
    .i_pop        (w_pop),
    .o_pop_data_c (w_head),
    .o_full_c     (w_full),
    .o_empty_c    (w_empty),
    .o_count_c    (w_count)
  );

  // Next state and next registered RAM-port / response values
  always_comb begin
    w_next_state     = r_state;
    w_pop            = 1'b0;
    w_we_next        = 1'b0;
    w_oe_next        = 1'b0;
    w_addr_next      = r_address;
    w_din_next       = r_data_in;
    w_rsp_valid_next = 1'b0;
    w_rsp_data_next  = r_rsp_data;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_addr_next = w_head_addr;
          if (w_head_write) begin
            w_next_state = WRITE;
            w_we_next    = 1'b1;
            w_din_next   = w_head_data;
          end else begin
            w_next_state = READ_ISSUE;
            w_oe_next    = 1'b1;
          end
        end
      end
      WRITE:        w_next_state = IDLE;
      READ_ISSUE:   w_next_state = READ_CAPTURE;
      READ_CAPTURE: begin
        w_next_state     = IDLE;
        w_rsp_valid_next = 1'b1;
        w_rsp_data_next  = data_out;
      end
      default:      w_next_state = IDLE;
    endcase
  end

  // Busy reflects the post-edge FIFO occupancy and state
  assign w_count_next = w_count + PTR_W'(w_push) - PTR_W'(w_pop);
  assign w_busy_next  = (w_next_state != IDLE) || (w_count_next != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_write_enable  <= 1'b0;
      r_output_enable <= 1'b0;
      r_address       <= '0;
      r_data_in       <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_write_enable  <= w_we_next;
      r_output_enable <= w_oe_next;
      r_address       <= w_addr_next;
      r_data_in       <= w_din_next;
      r_rsp_valid     <= w_rsp_valid_next;
      r_rsp_data      <= w_rsp_data_next;
      r_busy          <= w_busy_next;
    end
  end

  assign write_enable  = r_write_enable;
  assign output_enable = r_output_enable;
  assign address       = r_address;
  assign data_in       = r_data_in;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign busy          = r_busy;

`ifdef RAM_REQ_STATS_EN
  logic [15:0] r_write_count;
  logic [15:0] r_read_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_count <= '0;
      r_read_count  <= '0;
    end else begin
      if (r_state == WRITE && r_write_count != 16'hFFFF) r_write_count <= r_write_count + 16'd1;
      if (r_rsp_valid && r_read_count != 16'hFFFF)      r_read_count  <= r_read_count + 16'd1;
    end
  end

  assign write_count = r_write_count;
  assign read_count  = r_read_count;
`else
  assign write_count = '0;
  assign read_count  = '0;
`endif

endmodule

// File: tb/tb_ram_request_controller.sv
// Scoreboard bench for ram_request_controller: stimulus predicts RAM strobes and
// read responses from a flat memory model; a negedge monitor pops and compares.
module tb_ram_request_controller;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          write_enable;
  logic          output_enable;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out = '0;
  logic          busy;
  logic [15:0]   write_count;
  logic [15:0]   read_count;

  always #5 clk = ~clk;

  ram_request_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_address   (cmd_address),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .write_enable  (write_enable),
    .output_enable (output_enable),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .busy          (busy),
    .write_count   (write_count),
    .read_count    (read_count)
  );

  // Stub RAM port with registered read data
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (write_enable)  ram[address] <= data_in;
    if (output_enable) data_out <= ram[address];
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } strobe_t;

  strobe_t       exp_strobe[$];
  logic [DW-1:0] exp_rsp[$];
  logic [DW-1:0] ref_mem [256];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_rd = 0;
  int stall_cycles = 0;
  int accept_cyc = 0;
  int last_strobe_cyc = 0;
  int last_rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every RAM strobe and response is matched against the front of its queue
  always @(negedge clk) begin : monitor
    strobe_t e;
    if (!reset) begin
      if (write_enable || output_enable) begin
        check("enables_exclusive", 32'(write_enable & output_enable), 32'd0);
        check("strobe_expected", 32'(exp_strobe.size() != 0), 32'd1);
        if (exp_strobe.size() != 0) begin
          e = exp_strobe.pop_front();
          check("strobe_kind", 32'(write_enable), 32'(e.wr));
          check("strobe_addr", 32'(address), 32'(e.a));
          if (e.wr) check("strobe_data", 32'(data_in), 32'(e.d));
        end
        last_strobe_cyc = cyc;
      end
      if (rsp_valid) begin
        check("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
        if (exp_rsp.size() != 0) check("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
        last_rsp_cyc = cyc;
      end
    end
  end

  // Offer one command; the reference model records it on the edge that accepts it
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int guard = 0;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_address = a;
    cmd_data    = d;
    while (!cmd_ready) begin
      stall_cycles++;
      guard++;
      if (guard > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL cmd_ready_timeout: got ready 0 for %0d cycles, required 1", guard);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (wr) begin
      ref_mem[a] = d;
      exp_strobe.push_back('{wr: 1'b1, a: a, d: d});
      n_wr++;
    end else begin
      exp_strobe.push_back('{wr: 1'b0, a: a, d: '0});
      exp_rsp.push_back(ref_mem[a]);
      n_rd++;
    end
    accept_cyc = cyc + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_strobe.size() != 0 || exp_rsp.size() != 0 || busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_done", 32'(guard < 500), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    logic [15:0] exp_wc;
    logic [15:0] exp_rc;
`ifdef RAM_REQ_STATS_EN
    exp_wc = 16'(n_wr);
    exp_rc = 16'(n_rd);
`else
    exp_wc = 16'd0;
    exp_rc = 16'd0;
`endif
    check({tag, "_write_count"}, 32'(write_count), 32'(exp_wc));
    check({tag, "_read_count"},  32'(read_count),  32'(exp_rc));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_write_enable"},  32'(write_enable),  32'd0);
    check({tag, "_output_enable"}, 32'(output_enable), 32'd0);
    check({tag, "_rsp_valid"},     32'(rsp_valid),     32'd0);
    check({tag, "_rsp_data"},      32'(rsp_data),      32'd0);
    check({tag, "_address"},       32'(address),       32'd0);
    check({tag, "_data_in"},       32'(data_in),       32'd0);
    check({tag, "_busy"},          32'(busy),          32'd0);
  endtask

  initial begin : global_timeout
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int guard;
    int rsp_seen;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_counts("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write then read back the same location
    send(1'b1, 8'h10, 8'hA5);
    send(1'b0, 8'h10, 8'h00);
    drain();

    // Single read from an idle, empty block: strobe and response latency
    send(1'b0, 8'h10, 8'h00);
    drain();
    check("strobe_latency_ok", 32'((last_strobe_cyc - accept_cyc) >= 1 && (last_strobe_cyc - accept_cyc) <= 2), 32'd1);
    check("rsp_latency_ok",    32'((last_rsp_cyc - accept_cyc) >= 3 && (last_rsp_cyc - accept_cyc) <= 4), 32'd1);

    // Interleaved read / write / read
    send(1'b0, 8'h01, 8'h00);
    send(1'b1, 8'h02, 8'h3C);
    send(1'b0, 8'h02, 8'h00);
    drain();

    // Reads keep the FSM busy so the following writes must fill the FIFO
    stall_cycles = 0;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(8'h20 + i), 8'h00);
    for (int i = 0; i < 6; i++) send(1'b1, AW'(8'h30 + i), DW'(8'h80 + i));
    drain();
    check("backpressure_seen", 32'(stall_cycles > 0), 32'd1);
    check_counts("pre_reset");

    // Reset while a read is being issued with further reads queued
    for (int i = 0; i < 4; i++) send(1'b0, AW'(8'h40 + i), 8'h00);
    guard = 0;
    while (!output_enable && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("read_issue_seen", 32'(output_enable), 32'd1);
    #1;
    reset = 1'b1;
    exp_strobe.delete();
    exp_rsp.delete();
    n_wr = 0;
    n_rd = 0;
    #1;
    check_idle_outputs("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || write_enable || output_enable) rsp_seen++;
    end
    check("no_activity_after_reset", 32'(rsp_seen), 32'd0);
    check("busy_after_reset", 32'(busy), 32'd0);
    check_counts("post_reset");

    // Three writes and two reads for the completion counters
    send(1'b1, 8'h50, 8'h11);
    send(1'b1, 8'h51, 8'h22);
    send(1'b0, 8'h50, 8'h00);
    send(1'b1, 8'h52, 8'h33);
    send(1'b0, 8'h52, 8'h00);
    drain();
    check_counts("stats_3w2r");

    // Twelve back-to-back commands wrap the depth-4 pointers several times
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) send(1'b1, AW'(8'h60 + i), DW'(8'hC0 + i));
      else            send(1'b0, AW'(8'h60 + i - 1), 8'h00);
    end
    drain();

    // Randomized traffic over a small address window to force read-after-write hits
    for (int i = 0; i < 80; i++) begin
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom()));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_request_controller.md
RAM_REQUEST_CONTROLLER -- requirements
Module: ram_request_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command buffer entries, power of two, minimum 2.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; all state is clocked on the rising edge of clk.
REQ-005 Ports: clk  in  1  clock.
REQ-006 Ports: reset  in  1  asynchronous active-high reset.
REQ-007 Ports: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted this edge if also valid.
REQ-008 Ports: cmd_write  in  1  1=write, 0=read; cmd_address  in  ADDR_WIDTH; cmd_data  in  DATA_WIDTH  write data.
REQ-009 Ports: rsp_valid  out  1  one-cycle read-data strobe; rsp_data  out  DATA_WIDTH  read data.
REQ-010 Ports: write_enable, output_enable  out  1 each; address  out  ADDR_WIDTH; data_in  out  DATA_WIDTH  (drive one dual-port RAM port).
REQ-011 Ports: data_out  in  DATA_WIDTH  RAM registered read data; busy  out  1  FIFO non-empty or FSM not IDLE.
REQ-012 Ports: write_count, read_count  out  16 each  completed-operation counters.

Function
REQ-013 SHALL accept a command on any edge with cmd_valid && cmd_ready and push {write, address, data} into the FIFO.
REQ-014 SHALL drive cmd_ready = !fifo_full combinationally; a pop on the same edge SHALL NOT raise cmd_ready while full.
REQ-015 SHALL use FSM states IDLE, WRITE, READ_ISSUE, READ_CAPTURE.
REQ-016 IDLE: if FIFO non-empty, pop head; go to WRITE if write, else READ_ISSUE; stay IDLE if empty.
REQ-017 WRITE: write_enable=1, address/data_in from popped command for exactly one cycle; then IDLE.
REQ-018 READ_ISSUE: output_enable=1, address from popped command for one cycle; then READ_CAPTURE.
REQ-019 READ_CAPTURE: register data_out into rsp_data and pulse rsp_valid for the following cycle; then IDLE.
REQ-020 Command accepted at edge N into an empty idle block SHALL produce its RAM strobe in cycle N+1..N+2; a read SHALL show rsp_valid in cycle N+3..N+4.
REQ-021 Commands SHALL complete strictly in acceptance order; no response backpressure exists.
REQ-022 write_enable and output_enable SHALL never be high together; both SHALL be 0 outside WRITE/READ_ISSUE.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-024 Push and pop on the same edge with FIFO neither full nor empty SHALL keep occupancy unchanged.

Reset
REQ-025 On reset SHALL go to IDLE, empty FIFO, and clear rsp_valid, rsp_data, write_enable, output_enable, address, data_in, busy, write_count, read_count to 0.
REQ-026 Reset mid-operation SHALL drop buffered and in-flight commands; no rsp_valid SHALL follow for a dropped read.

Configuration
REQ-027 Macro RAM_REQ_STATS_EN SHALL compile in counters: write_count increments on each WRITE cycle, read_count on each rsp_valid pulse, both saturating at 16'hFFFF.
REQ-028 Without RAM_REQ_STATS_EN, write_count and read_count SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-029 Package ram_ctrl_pkg SHALL hold the FSM state encoding, the command-record width constant, and default parameter values.
REQ-030 The command buffer SHALL be sub-module ram_cmd_fifo (synchronous, same clk/reset, push/pop/full/empty).

Verification
REQ-031 Write addr 0x10 data 0xA5, then read 0x10 (stub RAM) -> one write_enable pulse at 0x10/0xA5; rsp_valid once with rsp_data 0xA5.
REQ-032 Hold cmd_valid with 5 writes while FSM is held busy -> cmd_ready low after 4 accepted; all 5 execute in order.
REQ-033 Interleave read 0x01, write 0x02=0x3C, read 0x02 -> strobes in that order, responses 0x00 then 0x3C, never both enables high.
REQ-034 Assert reset during READ_ISSUE with 2 queued commands -> all outputs 0 immediately; no rsp_valid; busy 0 after release.
REQ-035 With RAM_REQ_STATS_EN, 3 writes and 2 reads -> write_count 3, read_count 2; without macro both read 0.
REQ-036 Push 12 commands through a depth-4 FIFO -> pointers wrap twice, order preserved, no loss or duplication.
